// File: rtl/arb_frame_requester_pkg.sv
// Shared definitions for the frame requester: read-side state encoding and sticky error bit indices.
package arb_frame_requester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_GAP  = 2'd3
  } rd_state_t;

  localparam int ERR_GRANT_LOST = 0;
  localparam int ERR_OVERSIZE   = 1;
  localparam int NUM_ERR        = 2;

endpackage

// File: rtl/arb_frame_requester_frame_fifo.sv
// Single-clock word FIFO whose write pointer can be rolled back to the last committed frame boundary.
module arb_frame_requester_frame_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  input  logic          rollback,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          full,
  output logic          empty,
  output logic          partial
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  logic [DW:0] mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] commit_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] used;

  // Occupancy counts uncommitted words too, so a growing frame can fill the FIFO.
  assign used    = wr_ptr - rd_ptr;
  assign full    = (used == FULL_LVL);
  assign empty   = (rd_ptr == commit_ptr);
  assign partial = (wr_ptr != commit_ptr);

  assign {rd_last, rd_data} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      if (rollback) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (wr_last) commit_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rollback) mem[wr_ptr[AW-1:0]] <= {wr_last, wr_data};
  end

endmodule

// File: rtl/arb_frame_requester.sv
// Requester side of the round-robin bus arbiter: buffers whole frames, requests the bus,
// and streams one frame per grant before releasing req for a fixed idle gap.
module arb_frame_requester
  import arb_frame_requester_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 4,
  parameter int REQ_GAP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          req,
  input  logic          grant,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_valid,
  output logic [AW:0]   frame_cnt,
  output logic          err_grant_lost,
  output logic          err_oversize,
  input  logic          err_clr,
  output logic [1:0]    state_dbg
);

  localparam logic [3:0] GAP_LOAD = 4'(REQ_GAP - 1);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  rd_state_t state;
  logic [3:0] gap_cnt;
  logic discarding;
  logic [NUM_ERR-1:0] err_q;
  logic [NUM_ERR-1:0] err_evt;

  logic fifo_full;
  logic fifo_empty;
  logic fifo_partial;
  logic [DW-1:0] rd_data;
  logic rd_last;
  logic wr_en;
  logic rollback;
  logic pop;
  logic pop_last;
  logic frame_in;

  // Handshake: a source word moves when in_valid && in_ready; while discarding,
  // every offered word is accepted and thrown away. The bus side never stalls.
  assign in_ready = discarding || !fifo_full;
  assign wr_en    = in_valid && !fifo_full && !discarding;
  assign frame_in = wr_en && in_last;
  assign rollback = fifo_full && fifo_partial && !discarding;
  assign pop      = (state == ST_XFER) && grant && !fifo_empty;
  assign pop_last = pop && rd_last;

  assign err_evt[ERR_GRANT_LOST] = (state == ST_XFER) && !grant;
  assign err_evt[ERR_OVERSIZE]   = rollback;
  assign err_grant_lost = err_q[ERR_GRANT_LOST];
  assign err_oversize   = err_q[ERR_OVERSIZE];
  assign state_dbg      = state;

  arb_frame_requester_frame_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (in_data),
    .wr_last  (in_last),
    .rollback (rollback),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .partial  (fifo_partial)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      discarding <= 1'b0;
      frame_cnt  <= '0;
      err_q      <= '0;
    end else begin
      if (rollback) discarding <= 1'b1;
      else if (discarding && in_valid && in_last) discarding <= 1'b0;
      case ({frame_in, pop_last})
        2'b10:   frame_cnt <= frame_cnt + CNT_ONE;
        2'b01:   frame_cnt <= frame_cnt - CNT_ONE;
        default: frame_cnt <= frame_cnt;
      endcase
      // A new event in the same cycle as err_clr keeps the flag set.
      err_q <= (err_q & {NUM_ERR{!err_clr}}) | err_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      req       <= 1'b0;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= pop;
      out_last  <= pop_last;
      out_data  <= pop ? rd_data : '0;
      case (state)
        ST_IDLE: begin
          if (frame_cnt != '0) begin
            state <= ST_REQ;
            req   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (grant) state <= ST_XFER;
        end
        ST_XFER: begin
          // req falls together with the final word so the arbiter can rotate.
          if (pop_last) begin
            state   <= ST_GAP;
            req     <= 1'b0;
            gap_cnt <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            if (frame_cnt != '0) begin
              state <= ST_REQ;
              req   <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_frame_requester.sv
// Directed and randomized bench for arb_frame_requester with a word-order scoreboard on the bus.
module tb_arb_frame_requester;

  localparam int DW      = 16;
  localparam int AW      = 2;
  localparam int DEPTH   = 1 << AW;
  localparam int REQ_GAP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic          req;
  logic          grant;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic [AW:0]   frame_cnt;
  logic          err_grant_lost;
  logic          err_oversize;
  logic          err_clr;
  logic [1:0]    state_dbg;

  logic grant_tie;
  logic grant_drv;
  logic rand_mode;
  logic rnd_bit = 1'b0;
  logic g_edge = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW:0] exp_q[$];

  arb_frame_requester #(.DW(DW), .AW(AW), .REQ_GAP(REQ_GAP)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .req            (req),
    .grant          (grant),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .frame_cnt      (frame_cnt),
    .err_grant_lost (err_grant_lost),
    .err_oversize   (err_oversize),
    .err_clr        (err_clr),
    .state_dbg      (state_dbg)
  );

  // clock / reset helpers
  always #5 clk = ~clk;

  assign grant = grant_tie ? req : (rand_mode ? (req & rnd_bit) : grant_drv);

  always @(posedge clk) begin
    g_edge = grant;
    rnd_bit <= ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every bus word must be the next expected word of a kept frame
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("bus_extra_word", 64'(exp_q.size()), 64'd1);
        end else begin
          check("bus_word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
          check("bus_needs_grant", 64'(g_edge), 64'd1);
          if (out_last) check("req_low_on_last", 64'(req), 64'd0);
        end
      end else begin
        check("bus_idle_zero", 64'({out_last, out_data}), 64'd0);
      end
    end
  end

  // driver tasks
  task automatic send_word(input logic [DW-1:0] d, input logic l, input logic keep);
    int t;
    logic acc;
    t = 0;
    acc = 1'b0;
    if (keep) exp_q.push_back({l, d});
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      #1 acc = in_ready;
      @(posedge clk);
      if (acc) break;
      t++;
      if (t > 300) break;
      @(negedge clk);
    end
    check("send_accept", 64'(acc), 64'd1);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [DW-1:0] base, input logic keep);
    for (int i = 0; i < len; i++) send_word(base + DW'(i), (i == len - 1), keep);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (!req && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_rise", 64'(req), 64'd1);
  endtask

  // length of the next out_valid burst, then req-low cycles counted from the out_last cycle
  task automatic burst_gap(output int n, output int gap);
    int t;
    logic was_last;
    n = 0;
    gap = 0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 80) begin
      @(negedge clk);
      t++;
    end
    was_last = 1'b0;
    while (out_valid && n < 40) begin
      n++;
      was_last = out_last;
      @(negedge clk);
      if (was_last) break;
    end
    if (was_last) begin
      gap = 1;
      while (!req && gap < 40) begin
        gap++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int n;
    int gap;
    int t;
    int len;
    logic [DW-1:0] base;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    err_clr = 1'b0;
    grant_tie = 1'b1;
    grant_drv = 1'b0;
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_errs", 64'({err_grant_lost, err_oversize}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(in_ready), 64'd1);

    // single 3-word frame, grant follows req
    send_word(16'h000A, 1'b0, 1'b1);
    send_word(16'h000B, 1'b0, 1'b1);
    send_word(16'h000C, 1'b1, 1'b1);
    check("single_cnt", 64'(frame_cnt), 64'd1);
    burst_gap(n, gap);
    check("single_len", 64'(n), 64'd3);
    check("single_cnt_done", 64'(frame_cnt), 64'd0);
    check("single_req_low", 64'(req), 64'd0);

    // two committed frames sent back to back
    @(negedge clk);
    grant_tie = 1'b0;
    grant_drv = 1'b0;
    send_frame(2, 16'h0100, 1'b1);
    send_frame(1, 16'h0200, 1'b1);
    check("b2b_cnt2", 64'(frame_cnt), 64'd2);
    @(negedge clk);
    grant_tie = 1'b1;
    burst_gap(n, gap);
    check("b2b_len1", 64'(n), 64'd2);
    check("b2b_gap", 64'(gap), 64'(REQ_GAP));
    check("b2b_cnt1", 64'(frame_cnt), 64'd1);
    burst_gap(n, gap);
    check("b2b_len2", 64'(n), 64'd1);
    check("b2b_cnt0", 64'(frame_cnt), 64'd0);

    // grant withdrawn for two cycles after the first of four words
    @(negedge clk);
    grant_tie = 1'b0;
    grant_drv = 1'b0;
    send_frame(DEPTH, 16'h0300, 1'b1);
    check("lost_cnt", 64'(frame_cnt), 64'd1);
    check("full_not_ready", 64'(in_ready), 64'd0);
    wait_req();
    @(negedge clk);
    grant_drv = 1'b1;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("lost_first_word", 64'(out_valid), 64'd1);
    grant_drv = 1'b0;
    @(negedge clk);
    check("lost_flag", 64'(err_grant_lost), 64'd1);
    check("lost_req_held", 64'(req), 64'd1);
    check("lost_pause1", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("lost_pause2", 64'(out_valid), 64'd0);
    grant_drv = 1'b1;
    burst_gap(n, gap);
    check("lost_rest_len", 64'(n), 64'd3);
    grant_drv = 1'b0;
    check("lost_cnt0", 64'(frame_cnt), 64'd0);
    pulse_clr();
    check("lost_clr", 64'(err_grant_lost), 64'd0);

    // oversize frame behind a committed 2-word frame
    grant_tie = 1'b0;
    send_frame(2, 16'h0400, 1'b1);
    send_frame(6, 16'h0500, 1'b0);
    check("ovs_flag", 64'(err_oversize), 64'd1);
    check("ovs_cnt", 64'(frame_cnt), 64'd1);
    check("ovs_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    grant_tie = 1'b1;
    burst_gap(n, gap);
    check("ovs_len", 64'(n), 64'd2);
    check("ovs_cnt0", 64'(frame_cnt), 64'd0);
    pulse_clr();
    check("ovs_clr", 64'(err_oversize), 64'd0);

    // asynchronous reset while a frame waits for grant
    @(negedge clk);
    grant_tie = 1'b0;
    grant_drv = 1'b0;
    send_frame(2, 16'h0600, 1'b1);
    wait_req();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_req", 64'(req), 64'd0);
    check("arst_cnt", 64'(frame_cnt), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ready", 64'(in_ready), 64'd1);
    grant_tie = 1'b1;
    send_frame(1, 16'h0055, 1'b1);
    burst_gap(n, gap);
    check("arst_fresh_len", 64'(n), 64'd1);

    // randomized frames with a stuttering grant
    @(negedge clk);
    grant_tie = 1'b0;
    rand_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, DEPTH + 2);
      base = DW'($urandom);
      if (len <= DEPTH) begin
        t = 0;
        while (exp_q.size() + len > DEPTH && t < 500) begin
          @(negedge clk);
          t++;
        end
        send_frame(len, base, 1'b1);
      end else begin
        send_frame(len, base, 1'b0);
        check("rand_ovs_flag", 64'(err_oversize), 64'd1);
        pulse_clr();
        check("rand_ovs_clr", 64'(err_oversize), 64'd0);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    rand_mode = 1'b0;
    grant_tie = 1'b1;
    t = 0;
    while ((exp_q.size() != 0 || frame_cnt != '0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_cnt0", 64'(frame_cnt), 64'd0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
